// File: rtl/alu_serial_rx.sv
// Serial receiver for the ALU: deserialises 8 DATA + 1 CTL packets into
// operands B/A and an opcode, checks framing, CRC4 and opcode legality.
module alu_serial_rx #(
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic        cmd_valid,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [2:0]  op,
  output logic        err_valid,
  output logic [2:0]  err_flags
);

  localparam int TW = $clog2(IDLE_TIMEOUT + 1) + 1;
  localparam logic [TW-1:0] TMO_MAX = TW'(IDLE_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TYPE,
    S_BITS,
    S_STOP
  } state_t;

  state_t        r_state;
  logic          r_type;
  logic [7:0]    r_sh;
  logic [2:0]    r_bit;
  logic [3:0]    r_pkt;
  logic [63:0]   r_data;
  logic [TW-1:0] r_tmo;

  logic [2:0]    w_op;
  logic [3:0]    w_crc_rx;
  logic [3:0]    w_crc_calc;
  logic          w_op_ok;
  logic          w_pkt_full;

  // x^4+x+1, init 0, MSB first over {B, A, 1'b1, op}
  function automatic logic [3:0] crc4(input logic [67:0] m);
    logic [3:0] c;
    logic       fb;
    c = 4'h0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ m[i];
      c  = {c[2:0], 1'b0} ^ (fb ? 4'h3 : 4'h0);
    end
    return c;
  endfunction

  assign w_op       = r_sh[6:4];
  assign w_crc_rx   = r_sh[3:0];
  assign w_crc_calc = crc4({r_data, 1'b1, w_op});
  assign w_pkt_full = (r_pkt == 4'd8);

  always_comb begin
    w_op_ok = 1'b0;
    unique case (w_op)
      3'b000,
      3'b001,
      3'b100,
      3'b101:  w_op_ok = 1'b1;
      default: w_op_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_type    <= 1'b0;
      r_sh      <= 8'h00;
      r_bit     <= 3'd0;
      r_pkt     <= 4'd0;
      r_data    <= 64'h0;
      r_tmo     <= '0;
      cmd_valid <= 1'b0;
      err_valid <= 1'b0;
      a         <= 32'h0;
      b         <= 32'h0;
      op        <= 3'b000;
      err_flags <= 3'b000;
    end else begin
      cmd_valid <= 1'b0;
      err_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (!sin) begin
            r_tmo   <= '0;
            r_state <= S_TYPE;
          end else if (r_pkt != 4'd0) begin
            // a partial frame left idle too long is abandoned
            if (r_tmo == TMO_MAX) begin
              r_tmo     <= '0;
              r_pkt     <= 4'd0;
              err_valid <= 1'b1;
              err_flags <= 3'b100;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
          end else begin
            r_tmo <= '0;
          end
        end
        S_TYPE: begin
          r_type  <= sin;
          r_bit   <= 3'd0;
          r_state <= S_BITS;
        end
        S_BITS: begin
          r_sh  <= {r_sh[6:0], sin};
          r_bit <= r_bit + 3'd1;
          if (r_bit == 3'd7) begin
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          r_state <= S_IDLE;
          r_tmo   <= '0;
          if (!sin) begin
            r_pkt     <= 4'd0;
            err_valid <= 1'b1;
            err_flags <= 3'b100;
          end else if (!r_type) begin
            if (w_pkt_full) begin
              r_pkt     <= 4'd0;
              err_valid <= 1'b1;
              err_flags <= 3'b100;
            end else begin
              r_data <= {r_data[55:0], r_sh};
              r_pkt  <= r_pkt + 4'd1;
            end
          end else begin
            r_pkt <= 4'd0;
            if (!w_pkt_full) begin
              err_valid <= 1'b1;
              err_flags <= 3'b100;
            end else if (w_crc_calc != w_crc_rx) begin
              err_valid <= 1'b1;
              err_flags <= 3'b010;
            end else if (!w_op_ok) begin
              err_valid <= 1'b1;
              err_flags <= 3'b001;
            end else begin
              cmd_valid <= 1'b1;
              b         <= r_data[63:32];
              a         <= r_data[31:0];
              op        <= w_op;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_serial_rx.md
Name: alu_serial_rx

Overview:
- Serial input deserializer for the ALU. Samples the `sin` line and assembles 8 DATA packets plus 1 CTL packet into operands B and A and an opcode.
- Checks framing, CRC4 and opcode legality, then presents either a valid command or an error code to the ALU core. A single-cycle strobe qualifies each result.
- Sits between the `sin` pin and the ALU datapath. It is the receiving end of the testbench's serial send path.

Parameters:
- IDLE_TIMEOUT, 64, max clk cycles the line may sit idle between packets inside a frame before the frame is aborted with a data error.

Ports:
- clk  input  1  system clock; all sampling on posedge.
- rst_n  input  1  asynchronous active-low reset.
- sin  input  1  serial input; idles at 1.
- cmd_valid  output  1  one-cycle strobe: a good frame is available on a/b/op.
- a  output  32  operand A.
- b  output  32  operand B.
- op  output  3  opcode: 000 AND, 001 OR, 100 ADD, 101 SUB.
- err_valid  output  1  one-cycle strobe: frame rejected; err_flags valid.
- err_flags  output  3  {err_data, err_crc, err_op}; exactly one bit set when err_valid=1.

Behaviour:
- Reset:
  - rst_n=0 asynchronously clears all outputs to 0, state to IDLE and the packet counter to 0.
  - Reset mid-frame discards the partial frame with no strobe.
- Packet format: 11 bits, one bit per clk, MSB first.
  - start bit = 0.
  - type bit: 0 = DATA, 1 = CTL.
  - 8 payload bits, bit7 first.
  - stop bit = 1.
- Bit FSM:
  - IDLE: wait for sin==0.
  - TYPE: next posedge latches the type bit.
  - BITS: 8 posedges shift in the payload, MSB first.
  - STOP: next posedge samples the stop bit; if 0 → framing error. Then return to IDLE.
  - Back-to-back packets with no idle gap are legal.
- Frame assembly:
  - pkt_cnt counts DATA packets, 0..8.
  - Data order on the wire: B[31:24], B[23:16], B[15:8], B[7:0], A[31:24], A[23:16], A[15:8], A[7:0].
  - The CTL payload is {1'b0, op[2:0], crc4[3:0]}.
- CRC4:
  - Polynomial x^4+x+1, initial value 0.
  - Computed over the 68-bit vector {B, A, 1'b1, op}, MSB first.
  - Compared against the received crc4.
- Outputs:
  - Result strobes are asserted on the cycle after the CTL stop bit is sampled, for exactly 1 cycle.
  - a/b/op are updated only on cmd_valid and hold otherwise.
  - err_flags is updated on err_valid and holds until the next strobe.
- Error rules, priority err_data > err_crc > err_op:
  - err_data:
    - CTL received with pkt_cnt != 8;
    - a 9th DATA packet received;
    - stop bit == 0;
    - idle gap > IDLE_TIMEOUT while pkt_cnt > 0.
    - For a 9th DATA packet, a bad stop bit or a timeout, err_valid is asserted 1 cycle after detection.
  - err_crc: 8 DATA packets + CTL with a CRC mismatch.
  - err_op: CRC correct but op not in {000,001,100,101}.
- After any strobe (good or error), pkt_cnt resets to 0 and the receiver waits for a new frame.
- cmd_valid and err_valid are never asserted together.
- The timeout counter runs only in IDLE with pkt_cnt > 0, and clears on each start bit.

Test Plan:
- Good ADD frame: send A=0x00000001, B=0x00000002, op=100 with correct CRC4. Required response: cmd_valid for 1 cycle; a=1, b=2, op=100; err_valid stays 0.
- CRC error: same frame with crc4 XOR 4'h1. Required response: err_valid=1, err_flags=3'b010; a/b/op keep their previous values.
- Short frame: send 7 DATA packets, then a CTL. Required response: err_valid=1, err_flags=3'b100.
- Illegal opcode: A=0xFFFFFFFF, B=0, op=010 with correct CRC4. Required response: err_flags=3'b001. A following good SUB frame (A=5, B=3) gives cmd_valid with op=101.
- Framing and timeout:
  - A DATA packet with stop bit 0 gives err_flags=3'b100.
  - 3 DATA packets followed by an idle gap of IDLE_TIMEOUT+1 cycles gives err_flags=3'b100.
  - The next full good frame is still accepted after either error.
- Async reset: assert rst_n=0 mid-way through the 5th DATA packet. Required response: all outputs read 0 immediately, no strobe; a complete good frame after release is accepted.
